test_data_sink: RTL and testbench
=================================

Name: test_data_sink

Overview:
- Receive end of the test-data path and the counterpart to the test data source.
- Accepts a valid/ready word stream and checks each word against a locally generated expected pattern (counter, LFSR or constant).
- Counts words, frames and errors, and captures the first mismatch.
- Control and status ports are mapped to AXI-Lite registers by a separate interface wrapper.

Parameters:
- DATA_WIDTH, 32, stream word width; multiple of 8, range 8..32. Expected word is the low DATA_WIDTH bits of the 32-bit generator.
- CNT_WIDTH, 32, width of all statistics counters.

Ports:
- axi_clk  in  1  sole clock
- axi_reset  in  1  synchronous, active-high reset
- s_data  in  DATA_WIDTH  stream word
- s_valid  in  1  word valid
- s_last  in  1  final word of frame
- s_ready  out  1  sink ready; registered, never combinationally dependent on s_valid
- enable  in  1  level: run checker
- clear  in  1  pulse: zero statistics and capture registers
- mode  in  2  0=counter, 1=LFSR, 2=constant, 3=count only (no data compare)
- seed  in  32  generator start value
- frame_len  in  16  expected words per frame; 0 disables frame check
- throttle  in  4  s_ready high 1 of every throttle+1 cycles
- stop_on_error  in  1  halt on first data mismatch
- state_o  out  2  0=IDLE, 1=RUN, 2=HALT
- word_count, error_count, frame_count, frame_error_count  out  CNT_WIDTH each  saturating at all-ones
- err_seen  out  1  sticky data-mismatch flag
- first_err_index  out  CNT_WIDTH  word_count value at first mismatch
- first_err_expected, first_err_actual  out  DATA_WIDTH each

Behaviour:
- Reset: all outputs 0, state IDLE, generator 0, throttle counter 0. Takes effect at the edge where axi_reset=1. Any in-flight stream state is discarded; no partial frame survives.
- Transfer: occurs on a cycle with s_valid=1 and s_ready=1. All counters and capture registers update at the following edge (1-cycle latency).
- IDLE: s_ready=0.
  - enable=1 → RUN. On that edge: latch mode and seed; zero statistics, err_seen and capture registers; load generator = seed (LFSR: seed 0 is replaced by 1); zero throttle and beat counters.
- RUN:
  - s_ready=1 when throttle counter=0. Throttle counter counts 0..throttle and wraps every cycle.
  - enable=0 → IDLE; statistics hold.
  - Mismatch with stop_on_error=1 → HALT.
- HALT: s_ready=0; statistics hold. enable=0 → IDLE.
- mode and seed changes during RUN or HALT are ignored until the next IDLE→RUN transition.
- Generator advances on every transfer, whether or not the word matched (no resync):
  - Counter: next = cur+1 mod 2^32.
  - LFSR: next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
  - Constant: unchanged.
- Compare: applies for mode≠3; mismatch when s_data ≠ gen[DATA_WIDTH-1:0]. On mismatch, error_count+1. If err_seen=0, capture first_err_index = current word_count, first_err_expected, first_err_actual, and set err_seen.
- word_count: +1 per transfer.
- frame_count: +1 per transfer with s_last=1.
- Frame check (frame_len≠0): beat counter counts transfers.
  - s_last=1 at beat≠frame_len-1 → frame_error_count+1.
  - s_last=0 at beat=frame_len-1 → frame_error_count+1.
  - Beat counter resets to 0 after s_last or after beat frame_len-1. At most one frame error per transfer.
- frame_len=0: beat counter idle; no frame errors.
- clear, in any state:
  - Zero statistics, err_seen and capture registers.
  - In RUN, also reload the generator from the latched seed and zero the beat and throttle counters.
  - State is unchanged.
  - Clear coincident with a transfer: clear wins and the word is not counted or compared.
- Saturation: a counter at all-ones stays there.

Test Plan:
- Counter mode, seed 0x10, throttle 0, 100 words 0x10..0x73 → word_count 100, error_count 0, s_ready continuously 1 from the cycle after enable.
- Same, but word 5 = 0xDEADBEEF → error_count 1, first_err_index 5, expected 0x15, actual 0xDEADBEEF; words 6.. (0x16..) match and error_count stays 1.
- LFSR mode, seed 0, words 0x1, 0x3, 0x6, 0xD → 0 errors; sending 0x1, 0x3, 0x7 → error_count 1, first_err_expected 0x6.
- frame_len 4; frames of 4, 4 and 3 words with s_last on the final word of each → frame_count 3, frame_error_count 1, word_count 11.
- throttle 2, s_valid held high for 30 cycles in RUN → exactly 10 transfers, s_ready pattern 1,0,0 repeating.
- stop_on_error=1, mismatch at word 3 → state HALT, s_ready 0, word_count 4.
  - Then clear → counts zero, state still HALT.
  - Then enable=0 → IDLE.
  - Separately, axi_reset mid-RUN → all outputs 0 at the next edge.

Source files
------------

// File: rtl/test_data_sink_if.sv
// Valid/ready word stream carried into the test data sink.
// The master drives words; the slave (sink) returns s_ready.
interface test_data_sink_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/test_data_sink.sv
// Receive end of the test-data path: checks a valid/ready word stream against a
// locally generated pattern and keeps word/frame/error statistics.
module test_data_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    test_data_sink_if.slave       s_if,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic [31:0]           seed,
    input  logic [15:0]           frame_len,
    input  logic [3:0]            throttle,
    input  logic                  stop_on_error,
    output logic [1:0]            state_o,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  frame_error_count,
    output logic                  err_seen,
    output logic [CNT_WIDTH-1:0]  first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_expected,
    output logic [DATA_WIDTH-1:0] first_err_actual
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] MODE_COUNTER  = 2'd0;
    localparam logic [1:0] MODE_LFSR     = 2'd1;
    localparam logic [1:0] MODE_CONSTANT = 2'd2;
    localparam logic [1:0] MODE_COUNT    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
    endfunction

    // An all-zero LFSR state would lock up, so seed 0 starts at 1.
    function automatic logic [31:0] gen_start(input logic [1:0] md, input logic [31:0] sd);
        if ((md == MODE_LFSR) && (sd == 32'd0)) begin
            return 32'd1;
        end else begin
            return sd;
        end
    endfunction

    function automatic logic [31:0] gen_step(input logic [1:0] md, input logic [31:0] cur);
        case (md)
            MODE_COUNTER:  return cur + 32'd1;
            MODE_LFSR:     return lfsr_next(cur);
            MODE_CONSTANT: return cur;
            default:       return cur;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            mode_r;
    logic [31:0]           seed_r;
    logic [31:0]           gen_r;
    logic [3:0]            thr_r;
    logic [15:0]           beat_r;
    logic                  s_ready_r;
    logic [CNT_WIDTH-1:0]  word_count_r;
    logic [CNT_WIDTH-1:0]  error_count_r;
    logic [CNT_WIDTH-1:0]  frame_count_r;
    logic [CNT_WIDTH-1:0]  frame_error_count_r;
    logic                  err_seen_r;
    logic [CNT_WIDTH-1:0]  first_err_index_r;
    logic [DATA_WIDTH-1:0] first_err_expected_r;
    logic [DATA_WIDTH-1:0] first_err_actual_r;

    logic [1:0]            state_nx_s;
    logic [1:0]            mode_nx_s;
    logic [31:0]           seed_nx_s;
    logic [31:0]           gen_nx_s;
    logic [3:0]            thr_nx_s;
    logic [15:0]           beat_nx_s;
    logic                  s_ready_nx_s;
    logic [CNT_WIDTH-1:0]  word_nx_s;
    logic [CNT_WIDTH-1:0]  error_nx_s;
    logic [CNT_WIDTH-1:0]  frame_nx_s;
    logic [CNT_WIDTH-1:0]  frame_error_nx_s;
    logic                  err_seen_nx_s;
    logic [CNT_WIDTH-1:0]  index_nx_s;
    logic [DATA_WIDTH-1:0] expected_nx_s;
    logic [DATA_WIDTH-1:0] actual_nx_s;
    logic                  zero_stats_s;

    logic                  xfer_s;
    logic                  mismatch_s;
    logic                  last_beat_s;
    logic [3:0]            thr_wrap_s;

    // A word clashing with clear is dropped: clear wins.
    assign xfer_s      = (state_r == ST_RUN) && s_ready_r && s_if.s_valid && !clear;
    assign mismatch_s  = xfer_s && (mode_r != MODE_COUNT) &&
                         (s_if.s_data != gen_r[DATA_WIDTH-1:0]);
    assign last_beat_s = (beat_r == (frame_len - 16'd1));
    assign thr_wrap_s  = (thr_r >= throttle) ? 4'd0 : (thr_r + 4'd1);

    // Next-state, generator, throttle/beat and statistics computation.
    always_comb begin
        state_nx_s       = state_r;
        mode_nx_s        = mode_r;
        seed_nx_s        = seed_r;
        gen_nx_s         = gen_r;
        thr_nx_s         = thr_r;
        beat_nx_s        = beat_r;
        word_nx_s        = word_count_r;
        error_nx_s       = error_count_r;
        frame_nx_s       = frame_count_r;
        frame_error_nx_s = frame_error_count_r;
        err_seen_nx_s    = err_seen_r;
        index_nx_s       = first_err_index_r;
        expected_nx_s    = first_err_expected_r;
        actual_nx_s      = first_err_actual_r;
        zero_stats_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nx_s   = ST_RUN;
                    mode_nx_s    = mode;
                    seed_nx_s    = seed;
                    gen_nx_s     = gen_start(mode, seed);
                    thr_nx_s     = 4'd0;
                    beat_nx_s    = 16'd0;
                    zero_stats_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    gen_nx_s  = gen_start(mode_r, seed_r);
                    thr_nx_s  = 4'd0;
                    beat_nx_s = 16'd0;
                end else if (xfer_s) begin
                    thr_nx_s  = thr_wrap_s;
                    gen_nx_s  = gen_step(mode_r, gen_r);
                    word_nx_s = sat_inc(word_count_r);
                    if (s_if.s_last) begin
                        frame_nx_s = sat_inc(frame_count_r);
                    end else begin
                        frame_nx_s = frame_count_r;
                    end
                    if (mismatch_s) begin
                        error_nx_s = sat_inc(error_count_r);
                        if (!err_seen_r) begin
                            err_seen_nx_s = 1'b1;
                            index_nx_s    = word_count_r;
                            expected_nx_s = gen_r[DATA_WIDTH-1:0];
                            actual_nx_s   = s_if.s_data;
                        end else begin
                            err_seen_nx_s = err_seen_r;
                        end
                    end else begin
                        error_nx_s = error_count_r;
                    end
                    // One frame error at most per word: early or missing s_last.
                    if (frame_len != 16'd0) begin
                        if (s_if.s_last != last_beat_s) begin
                            frame_error_nx_s = sat_inc(frame_error_count_r);
                        end else begin
                            frame_error_nx_s = frame_error_count_r;
                        end
                        if (s_if.s_last || last_beat_s) begin
                            beat_nx_s = 16'd0;
                        end else begin
                            beat_nx_s = beat_r + 16'd1;
                        end
                    end else begin
                        beat_nx_s = beat_r;
                    end
                end else begin
                    thr_nx_s = thr_wrap_s;
                end

                if (!enable) begin
                    state_nx_s = ST_IDLE;
                end else if (mismatch_s && stop_on_error) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!enable) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        s_ready_nx_s = (state_nx_s == ST_RUN) && (thr_nx_s == 4'd0);
    end

    // State, configuration, generator and statistics registers.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_r              <= ST_IDLE;
            mode_r               <= 2'd0;
            seed_r               <= 32'd0;
            gen_r                <= 32'd0;
            thr_r                <= 4'd0;
            beat_r               <= 16'd0;
            s_ready_r            <= 1'b0;
            word_count_r         <= CNT_ZERO;
            error_count_r        <= CNT_ZERO;
            frame_count_r        <= CNT_ZERO;
            frame_error_count_r  <= CNT_ZERO;
            err_seen_r           <= 1'b0;
            first_err_index_r    <= CNT_ZERO;
            first_err_expected_r <= DATA_ZERO;
            first_err_actual_r   <= DATA_ZERO;
        end else begin
            state_r   <= state_nx_s;
            mode_r    <= mode_nx_s;
            seed_r    <= seed_nx_s;
            gen_r     <= gen_nx_s;
            thr_r     <= thr_nx_s;
            beat_r    <= beat_nx_s;
            s_ready_r <= s_ready_nx_s;
            if (clear || zero_stats_s) begin
                word_count_r         <= CNT_ZERO;
                error_count_r        <= CNT_ZERO;
                frame_count_r        <= CNT_ZERO;
                frame_error_count_r  <= CNT_ZERO;
                err_seen_r           <= 1'b0;
                first_err_index_r    <= CNT_ZERO;
                first_err_expected_r <= DATA_ZERO;
                first_err_actual_r   <= DATA_ZERO;
            end else begin
                word_count_r         <= word_nx_s;
                error_count_r        <= error_nx_s;
                frame_count_r        <= frame_nx_s;
                frame_error_count_r  <= frame_error_nx_s;
                err_seen_r           <= err_seen_nx_s;
                first_err_index_r    <= index_nx_s;
                first_err_expected_r <= expected_nx_s;
                first_err_actual_r   <= actual_nx_s;
            end
        end
    end

    assign s_if.s_ready       = s_ready_r;
    assign state_o            = state_r;
    assign word_count         = word_count_r;
    assign error_count        = error_count_r;
    assign frame_count        = frame_count_r;
    assign frame_error_count  = frame_error_count_r;
    assign err_seen           = err_seen_r;
    assign first_err_index    = first_err_index_r;
    assign first_err_expected = first_err_expected_r;
    assign first_err_actual   = first_err_actual_r;

endmodule

// File: tb/tb_test_data_sink.sv
// Randomised and directed checks of test_data_sink against a transfer-indexed
// reference model (expected word computed from seed and transfer number).
module tb_test_data_sink;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          axi_clk = 1'b0;
    logic          axi_reset;
    logic          enable;
    logic          clear;
    logic [1:0]    mode;
    logic [31:0]   seed;
    logic [15:0]   frame_len;
    logic [3:0]    throttle;
    logic          stop_on_error;
    logic [1:0]    state_o;
    logic [CW-1:0] word_count;
    logic [CW-1:0] error_count;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] frame_error_count;
    logic          err_seen;
    logic [CW-1:0] first_err_index;
    logic [DW-1:0] first_err_expected;
    logic [DW-1:0] first_err_actual;

    test_data_sink_if #(.DATA_WIDTH(DW)) bus ();

    test_data_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .axi_clk            (axi_clk),
        .axi_reset          (axi_reset),
        .s_if               (bus.slave),
        .enable             (enable),
        .clear              (clear),
        .mode               (mode),
        .seed               (seed),
        .frame_len          (frame_len),
        .throttle           (throttle),
        .stop_on_error      (stop_on_error),
        .state_o            (state_o),
        .word_count         (word_count),
        .error_count        (error_count),
        .frame_count        (frame_count),
        .frame_error_count  (frame_error_count),
        .err_seen           (err_seen),
        .first_err_index    (first_err_index),
        .first_err_expected (first_err_expected),
        .first_err_actual   (first_err_actual)
    );

    always #5 axi_clk = ~axi_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: expected pattern is a function of (mode, seed, n).
    int          m_state;
    int          m_cyc;
    int          m_n;
    int          m_beat;
    logic [1:0]  m_mode;
    logic [31:0] m_seed;
    int          m_words, m_errs, m_frames, m_ferrs, m_idx;
    bit          m_seen;
    logic [31:0] m_exp, m_act;
    bit          m_xfer;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [1:0] md, input logic [31:0] sd, input int n);
        logic [31:0] v;
        case (md)
            2'd0: return sd + 32'(n);
            2'd1: begin
                v = (sd == 32'd0) ? 32'd1 : sd;
                for (int i = 0; i < n; i++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
                return v;
            end
            default: return sd;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic zero_stats();
        m_words = 0; m_errs = 0; m_frames = 0; m_ferrs = 0;
        m_seen = 0; m_idx = 0; m_exp = 32'd0; m_act = 32'd0;
    endtask

    task automatic model_step();
        bit          rdy, xf, mis, lastb;
        logic [31:0] w;
        m_xfer = 0;
        mis    = 0;
        if (axi_reset) begin
            m_state = 0; m_cyc = 0; m_n = 0; m_beat = 0;
            m_mode = 2'd0; m_seed = 32'd0;
            zero_stats();
            return;
        end
        rdy = (m_state == 1) && ((m_cyc % (int'(throttle) + 1)) == 0);
        xf  = rdy && bus.s_valid && !clear;
        case (m_state)
            0: if (enable) begin
                m_state = 1; m_mode = mode; m_seed = seed;
                m_n = 0; m_cyc = 0; m_beat = 0;
                zero_stats();
            end
            1: begin
                if (xf) begin
                    m_xfer = 1;
                    w   = exp_word(m_mode, m_seed, m_n);
                    mis = (m_mode != 2'd3) && (bus.s_data != w);
                    if (mis) begin
                        if (!m_seen) begin
                            m_seen = 1; m_idx = m_words; m_exp = w; m_act = bus.s_data;
                        end
                        m_errs = sat(m_errs);
                    end
                    m_words = sat(m_words);
                    if (bus.s_last) m_frames = sat(m_frames);
                    m_n++;
                    if (frame_len != 16'd0) begin
                        lastb = (m_beat == int'(frame_len) - 1);
                        if (bus.s_last != lastb) m_ferrs = sat(m_ferrs);
                        m_beat = (bus.s_last || lastb) ? 0 : m_beat + 1;
                    end
                end
                m_cyc++;
                if (clear) begin m_n = 0; m_cyc = 0; m_beat = 0; end
                if (!enable) m_state = 0;
                else if (mis && stop_on_error) m_state = 2;
            end
            default: if (!enable) m_state = 0;
        endcase
        if (clear) zero_stats();
    endtask

    task automatic compare_all();
        check_eq("state", 32'(state_o), 32'(m_state));
        check_eq("s_ready", 32'(bus.s_ready),
                 32'((m_state == 1) && ((m_cyc % (int'(throttle) + 1)) == 0)));
        check_eq("word_count", 32'(word_count), 32'(m_words));
        check_eq("error_count", 32'(error_count), 32'(m_errs));
        check_eq("frame_count", 32'(frame_count), 32'(m_frames));
        check_eq("frame_error_count", 32'(frame_error_count), 32'(m_ferrs));
        check_eq("err_seen", 32'(err_seen), 32'(m_seen));
        check_eq("first_err_index", 32'(first_err_index), 32'(m_idx));
        check_eq("first_err_expected", first_err_expected, m_exp);
        check_eq("first_err_actual", first_err_actual, m_act);
    endtask

    task automatic tick();
        @(posedge axi_clk);
        model_step();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_xfer) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                return;
            end
        end
        check_eq("send_timeout", 32'(m_xfer), 32'd1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] md, input logic [31:0] sd, input logic [3:0] thr,
                             input logic [15:0] fl, input logic soe);
        enable = 1'b0; clear = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        tick();
        mode = md; seed = sd; throttle = thr; frame_len = fl; stop_on_error = soe;
        enable = 1'b1;
        tick();
    endtask

    task automatic random_run(input int ncyc);
        logic [31:0] w;
        start_run(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 3)),
                  16'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
        for (int k = 0; k < ncyc; k++) begin
            enable = ($urandom_range(0, 39) != 0);
            clear  = ($urandom_range(0, 24) == 0);
            mode   = 2'($urandom_range(0, 3));
            seed   = $urandom;
            w = exp_word(m_mode, m_seed, m_n);
            if ($urandom_range(0, 9) == 0) w = w ^ ($urandom | 32'd1);
            bus.s_data  = w;
            bus.s_valid = ($urandom_range(0, 9) < 7);
            if ((frame_len != 16'd0) && (m_beat == int'(frame_len) - 1))
                bus.s_last = ($urandom_range(0, 7) != 0);
            else
                bus.s_last = ($urandom_range(0, 9) == 0);
            tick();
        end
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        axi_reset = 1'b1; enable = 1'b0; clear = 1'b0; mode = 2'd0; seed = 32'd0;
        frame_len = 16'd0; throttle = 4'd0; stop_on_error = 1'b0;
        bus.s_data = 32'd0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        tick();
        tick();
        check_eq("reset_state", 32'(state_o), 32'd0);
        check_eq("reset_ready", 32'(bus.s_ready), 32'd0);
        axi_reset = 1'b0;

        // Counter mode, 100 clean words; mode/seed changes after start are ignored
        start_run(2'd0, 32'h10, 4'd0, 16'd0, 1'b0);
        mode = 2'd2; seed = 32'hFFFF_FFFF;
        c0 = cyc;
        for (int i = 0; i < 100; i++) send_word(32'h10 + 32'(i), 1'b0);
        check_eq("s1_cycles", 32'(cyc - c0), 32'd100);
        check_eq("s1_words", 32'(word_count), 32'd100);
        check_eq("s1_errors", 32'(error_count), 32'd0);
        // clear coincident with a valid word: word not counted
        bus.s_valid = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; bus.s_valid = 1'b0;
        check_eq("clear_wins", 32'(word_count), 32'd0);

        // Counter mode with a corrupted word 5
        start_run(2'd0, 32'h10, 4'd0, 16'd0, 1'b0);
        for (int i = 0; i < 100; i++) send_word((i == 5) ? 32'hDEAD_BEEF : 32'h10 + 32'(i), 1'b0);
        check_eq("s2_errors", 32'(error_count), 32'd1);
        check_eq("s2_index", 32'(first_err_index), 32'd5);
        check_eq("s2_expected", first_err_expected, 32'h15);
        check_eq("s2_actual", first_err_actual, 32'hDEAD_BEEF);

        // LFSR mode, seed 0
        start_run(2'd1, 32'd0, 4'd0, 16'd0, 1'b0);
        send_word(32'h1, 1'b0); send_word(32'h3, 1'b0); send_word(32'h6, 1'b0); send_word(32'hD, 1'b0);
        check_eq("lfsr_ok_errors", 32'(error_count), 32'd0);
        start_run(2'd1, 32'd0, 4'd0, 16'd0, 1'b0);
        send_word(32'h1, 1'b0); send_word(32'h3, 1'b0); send_word(32'h7, 1'b0);
        check_eq("lfsr_bad_errors", 32'(error_count), 32'd1);
        check_eq("lfsr_bad_expected", first_err_expected, 32'h6);

        // Frames of 4, 4 and 3 with frame_len 4
        start_run(2'd0, 32'd0, 4'd0, 16'd4, 1'b0);
        for (int i = 0; i < 11; i++) send_word(32'(i), (i == 3) || (i == 7) || (i == 10));
        check_eq("frm_count", 32'(frame_count), 32'd3);
        check_eq("frm_errors", 32'(frame_error_count), 32'd1);
        check_eq("frm_words", 32'(word_count), 32'd11);

        // Throttle 2: ready 1,0,0 repeating
        start_run(2'd0, 32'd0, 4'd2, 16'd0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            check_eq("thr_pattern", 32'(bus.s_ready), 32'((k % 3) == 0));
            bus.s_data  = exp_word(m_mode, m_seed, m_n);
            bus.s_valid = 1'b1;
            tick();
        end
        bus.s_valid = 1'b0;
        check_eq("thr_words", 32'(word_count), 32'd10);

        // Stop on error at word 3, clear in HALT, then leave
        start_run(2'd0, 32'd0, 4'd0, 16'd0, 1'b1);
        send_word(32'd0, 1'b0); send_word(32'd1, 1'b0); send_word(32'd2, 1'b0); send_word(32'd99, 1'b0);
        check_eq("halt_state", 32'(state_o), 32'd2);
        check_eq("halt_ready", 32'(bus.s_ready), 32'd0);
        check_eq("halt_words", 32'(word_count), 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("halt_clear_words", 32'(word_count), 32'd0);
        check_eq("halt_clear_state", 32'(state_o), 32'd2);
        enable = 1'b0;
        tick();
        check_eq("halt_exit_state", 32'(state_o), 32'd0);

        // Saturation of counters in count-only mode
        start_run(2'd3, 32'd0, 4'd0, 16'd0, 1'b0);
        for (int i = 0; i < 300; i++) send_word($urandom, 1'b1);
        check_eq("sat_words", 32'(word_count), 32'(CMAX));
        check_eq("sat_frames", 32'(frame_count), 32'(CMAX));

        // Randomised runs
        for (int r = 0; r < 6; r++) random_run(200);

        // Reset in the middle of a run
        start_run(2'd0, 32'd5, 4'd1, 16'd3, 1'b0);
        send_word(32'd5, 1'b0); send_word(32'd0, 1'b0); send_word(32'd7, 1'b1);
        axi_reset = 1'b1;
        tick();
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_ready", 32'(bus.s_ready), 32'd0);
        check_eq("rst_words", 32'(word_count), 32'd0);
        check_eq("rst_errors", 32'(error_count), 32'd0);
        check_eq("rst_frames", 32'(frame_count), 32'd0);
        check_eq("rst_err_seen", 32'(err_seen), 32'd0);
        check_eq("rst_actual", first_err_actual, 32'd0);
        axi_reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
